// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI mode-0 slave that turns 48-bit frames into register
// writes and reads.
//   frame = {rw, addr[14:0], data[31:0]}, MSB first; rw=1 write, rw=0 read.
// Ports:
//   clk_100m, rst_syn           system clock, async active-high reset
//   spi_sclk/spi_cs_n/spi_mosi  raw SPI pins (async to clk_100m)
//   spi_miso, spi_miso_oe       serial out and its tristate enable
//   addr                        {1'b0, header address}, held until next header
//   data_mosi, data_mosi_rdy    write data and its one-cycle valid strobe
//   rd_req, rd_data             one-cycle read request; data sampled a cycle later
//   frame_err_cnt               saturating count of aborted frames
module spi_slave_regif #(
  parameter int ADDR_BITS    = 15,
  parameter int DATA_BITS    = 32,
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                    clk_100m,
  input  logic                    rst_syn,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  output logic [ADDR_BITS:0]      addr,
  output logic [DATA_BITS-1:0]    data_mosi,
  output logic                    data_mosi_rdy,
  output logic                    rd_req,
  input  logic [DATA_BITS-1:0]    rd_data,
  output logic [ERR_CNT_BITS-1:0] frame_err_cnt
);

  localparam int HDR_BITS = ADDR_BITS + 1;
  localparam int FRM_BITS = HDR_BITS + DATA_BITS;
  localparam int CNT_W    = 6;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] RD_LOAD = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // [0],[1] synchroniser, [2] history for edge detection
  logic [2:0] sclk_sr, cs_sr, mosi_sr;

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      sclk_sr <= 3'b000;
      cs_sr   <= 3'b111;
      mosi_sr <= 3'b000;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      cs_sr   <= {cs_sr[1:0], spi_cs_n};
      mosi_sr <= {mosi_sr[1:0], spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign cs_rise   = cs_sr[1] & ~cs_sr[2];
  assign cs_fall   = ~cs_sr[1] & cs_sr[2];
  // mosi history bit lines up with the sclk sample just before the rise was
  // seen, i.e. the data level at the moment of the rising edge.
  assign mosi_s    = mosi_sr[2];

  assign spi_miso_oe = ~cs_sr[1];

  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg, tx;
  logic [DATA_BITS-1:0] shreg_nxt;
  assign shreg_nxt = {shreg[DATA_BITS-2:0], mosi_s};

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      tx            <= '0;
      spi_miso      <= 1'b0;
      addr          <= '0;
      data_mosi     <= '0;
      data_mosi_rdy <= 1'b0;
      rd_req        <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      data_mosi_rdy <= 1'b0;
      rd_req        <= 1'b0;
      if (cs_rise && state != IDLE) begin
        // release before the frame finished counts as an abort; DONE is the
        // normal end
        state    <= IDLE;
        spi_miso <= 1'b0;
        if (state != DONE && frame_err_cnt != '1)
          frame_err_cnt <= frame_err_cnt + 1'b1;
      end else begin
        case (state)
          IDLE: begin
            spi_miso <= 1'b0;
            if (cs_fall) begin
              state   <= HEADER;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          HEADER: if (sclk_rise) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(HDR_BITS - 1)) begin
              addr <= {1'b0, shreg[ADDR_BITS-2:0], mosi_s};
              // rw bit was shifted in first, now one below the top of the header
              if (shreg[ADDR_BITS-1]) state <= WR_DATA;
              else begin
                rd_req <= 1'b1;
                state  <= RD_LOAD;
              end
            end
          end
          RD_LOAD: begin
            if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
            // rd_req is high our first cycle here; rd_data is valid the next
            if (!rd_req) begin
              tx    <= rd_data;
              state <= RD_DATA;
            end
          end
          WR_DATA: if (sclk_rise) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(FRM_BITS - 1)) begin
              data_mosi     <= shreg_nxt;
              data_mosi_rdy <= 1'b1;
              state         <= DONE;
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              spi_miso <= tx[DATA_BITS-1];
              tx       <= {tx[DATA_BITS-2:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FRM_BITS - 1)) begin
                spi_miso <= 1'b0;
                state    <= DONE;
              end
            end
          end
          DONE:    spi_miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
`timescale 1ns/1ps
module tb_spi_slave_regif;

  logic        clk_100m = 1'b0;
  logic        rst_syn  = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] addr;
  logic [31:0] data_mosi;
  logic        data_mosi_rdy, rd_req;
  logic [31:0] rd_data = 32'h0;
  logic [7:0]  frame_err_cnt;

  spi_slave_regif dut (
    .clk_100m(clk_100m), .rst_syn(rst_syn),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .addr(addr), .data_mosi(data_mosi), .data_mosi_rdy(data_mosi_rdy),
    .rd_req(rd_req), .rd_data(rd_data), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  int vectors = 0, miscompares = 0;

  // strobe monitors: running totals, frames look at deltas
  int          rdy_total = 0, req_total = 0;
  logic [15:0] req_addr = 16'h0;
  always @(negedge clk_100m) begin
    if (data_mosi_rdy) rdy_total++;
    if (rd_req) begin
      req_total++;
      req_addr = addr;
    end
  end

  // reference model state
  int          exp_err  = 0;
  logic [15:0] exp_addr = 16'h0;
  logic [31:0] exp_data = 32'h0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ck(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100m);
  endtask

  // Master side of one frame; nbits may be short (abort) or long (extra clocks).
  task automatic run_frame(input logic [47:0] f, input int nbits, input int half,
                           output logic [31:0] cap, output int rdy_d,
                           output int req_d, output logic oe_mid);
    int r0, q0;
    r0  = rdy_total;
    q0  = req_total;
    cap = 32'h0;
    @(negedge clk_100m);
    spi_cs_n = 1'b0;
    cyc(6);
    oe_mid = spi_miso_oe;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 48) ? f[47-i] : 1'($urandom);
      cyc(half);
      spi_sclk = 1'b1;
      if (i >= 16 && i < 48) cap[47-i] = spi_miso;
      cyc(half);
      spi_sclk = 1'b0;
    end
    cyc(half);
    spi_cs_n = 1'b1;
    cyc(8);
    rdy_d = rdy_total - r0;
    req_d = req_total - q0;
  endtask

  task automatic frame_and_check(input logic [47:0] f, input int nbits, input string tag);
    logic [31:0] cap;
    int          rdy_d, req_d;
    logic        oe_mid;
    bit          hdr, full, wr;
    wr   = f[47];
    hdr  = nbits >= 16;
    full = nbits >= 48;
    run_frame(f, nbits, 5, cap, rdy_d, req_d, oe_mid);
    if (hdr) exp_addr = {1'b0, f[46:32]};
    if (wr && full) exp_data = f[31:0];
    if (!full && exp_err < 255) exp_err++;
    ck({tag, ".rdy_pulses"}, 48'(rdy_d), 48'((wr && full) ? 1 : 0));
    ck({tag, ".rd_req_pulses"}, 48'(req_d), 48'((!wr && hdr) ? 1 : 0));
    ck({tag, ".addr"}, 48'(addr), 48'(exp_addr));
    ck({tag, ".data_mosi"}, 48'(data_mosi), 48'(exp_data));
    ck({tag, ".err_cnt"}, 48'(frame_err_cnt), 48'(exp_err));
    ck({tag, ".oe_in_frame"}, 48'(oe_mid), 48'(1));
    ck({tag, ".oe_idle"}, 48'(spi_miso_oe), 48'(0));
    ck({tag, ".miso_idle"}, 48'(spi_miso), 48'(0));
    if (req_d == 1) ck({tag, ".rd_req_addr"}, 48'(req_addr), 48'(exp_addr));
    if (!wr && full) ck({tag, ".miso_word"}, 48'(cap), 48'(rd_data));
  endtask

  task automatic ck_reset_vals(input string tag);
    ck({tag, ".miso"}, 48'(spi_miso), 48'(0));
    ck({tag, ".oe"}, 48'(spi_miso_oe), 48'(0));
    ck({tag, ".addr"}, 48'(addr), 48'(0));
    ck({tag, ".data_mosi"}, 48'(data_mosi), 48'(0));
    ck({tag, ".rdy"}, 48'(data_mosi_rdy), 48'(0));
    ck({tag, ".rd_req"}, 48'(rd_req), 48'(0));
    ck({tag, ".err_cnt"}, 48'(frame_err_cnt), 48'(0));
  endtask

  initial begin
    logic [47:0] f;
    int          nb;

    // reset state
    cyc(3);
    ck_reset_vals("reset");
    rst_syn = 1'b0;
    cyc(4);

    // directed write and read
    frame_and_check(48'h8004_0000_0123, 48, "wr_directed");
    rd_data = 32'hA5C3_0F81;
    frame_and_check(48'h0005_0000_0000, 48, "rd_directed");

    // random complete frames
    for (int k = 0; k < 20; k++) begin
      f = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      rd_data = $urandom;
      frame_and_check(f, 48, "rand_full");
    end

    // write aborted after 20 bits: data_mosi must keep its last value
    frame_and_check({1'b1, 15'h0033, 32'hDEAD_BEEF}, 20, "wr_abort20");

    // random aborts at assorted points, both directions
    for (int k = 0; k < 8; k++) begin
      f  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      nb = $urandom_range(0, 47);
      rd_data = $urandom;
      frame_and_check(f, nb, "rand_abort");
    end

    // extra clocks beyond the frame are ignored
    frame_and_check({1'b1, 15'h1ABC, 32'h1357_9BDF}, 52, "wr_52clk");

    // counter saturation
    for (int k = 0; k < 300; k++)
      frame_and_check({1'b1, 15'h0001, 32'h0}, 2, "sat_abort");
    ck("sat.final", 48'(frame_err_cnt), 48'(8'hFF));

    // reset during bit 30 of a read
    rd_data = 32'h0F0F_1234;
    f = {1'b0, 15'h0777, 32'h0};
    @(negedge clk_100m);
    spi_cs_n = 1'b0;
    cyc(6);
    for (int i = 0; i < 30; i++) begin
      spi_mosi = f[47-i];
      cyc(5);
      spi_sclk = 1'b1;
      cyc(5);
      spi_sclk = 1'b0;
    end
    spi_mosi = f[17];
    cyc(3);
    rst_syn  = 1'b1;
    spi_cs_n = 1'b1;
    cyc(2);
    ck_reset_vals("mid_reset");
    rst_syn = 1'b0;
    cyc(5);
    exp_err  = 0;
    exp_addr = 16'h0;
    exp_data = 32'h0;

    // frames after reset decode normally
    frame_and_check({1'b1, 15'h2468, 32'hCAFE_F00D}, 48, "post_rst_wr");
    rd_data = 32'h8000_0001;
    frame_and_check({1'b0, 15'h7FFF, 32'h0}, 48, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
- SPI slave front end for the 4MB control FPGA; sits directly upstream of the motor control blocks.
- Oversamples SPI pins on clk_100m and deserialises 48-bit frames.
- Write frames are delivered as addr / data_mosi / data_mosi_rdy. Read frames fetch one 32-bit word through the rd_req / rd_data port and shift it out on MISO.

Parameters:
ADDR_BITS, 15, address field width in frame header; addr output is zero-extended to 16 bits.
DATA_BITS, 32, data field width.
ERR_CNT_BITS, 8, width of aborted-frame counter.

Ports:
clk_100m  input  1  system clock, 100 MHz
rst_syn  input  1  asynchronous active-high reset
spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), max 10 MHz, asynchronous to clk_100m
spi_cs_n  input  1  chip select, active low, asynchronous
spi_mosi  input  1  serial data in, MSB first
spi_miso  output  1  serial data out, MSB first
spi_miso_oe  output  1  MISO output enable (tristate control at top level)
addr  output  16  frame address, {1'b0, hdr[14:0]}; held until next header completes
data_mosi  output  32  write data; held until next write completes
data_mosi_rdy  output  1  one-cycle strobe: addr/data_mosi valid write
rd_req  output  1  one-cycle strobe: read of addr requested
rd_data  input  32  read data from register mux; must be valid the cycle after rd_req
frame_err_cnt  output  8  saturating count of aborted frames

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, addr=0, data_mosi=0, data_mosi_rdy=0, rd_req=0, frame_err_cnt=0, state=IDLE, all sync flops=idle levels (sclk=0, cs_n=1).
- Sync: sclk, cs_n and mosi each pass through a 2-FF synchroniser plus a history flop.
  - sclk_rise / sclk_fall are single-cycle pulses derived from the synchronised signals; pin-to-pulse latency is 3 clocks.
  - mosi is sampled on sclk_rise.
- Frame format: bit 47 = RW (1=write, 0=read); bits 46:32 = address; bits 31:0 = data. Bit counter is 6 bits, counts rising edges.
- FSM states:
  - IDLE: wait for cs_n falling (synchronised) -> HEADER; clear bit counter and shift register.
  - HEADER: shift 16 bits. On the 16th sclk_rise, latch addr. If RW=1 -> WR_DATA. If RW=0 -> pulse rd_req next cycle and go to RD_LOAD.
  - RD_LOAD: cycle after rd_req, capture rd_data into tx shift register -> RD_DATA.
  - WR_DATA: shift 32 bits. On the 48th sclk_rise, data_mosi <= shift value and data_mosi_rdy=1 for exactly the next cycle -> DONE.
  - RD_DATA: on each sclk_fall, drive spi_miso = tx[31] and shift left. After the 48th sclk_rise -> DONE.
  - DONE: ignore further sclk edges; cs_n rising -> IDLE.
- spi_miso_oe = 1 while synchronised cs_n=0, else 0. spi_miso=0 outside RD_DATA.
- Abort: cs_n rising in HEADER, RD_LOAD, WR_DATA or RD_DATA -> IDLE with no data_mosi_rdy. frame_err_cnt increments and saturates at 8'hFF. A read abort after rd_req is still counted; rd_req is never retracted.
- cs_n rising in DONE is a normal end of frame, not an error. Any extra clocks beyond 48 are ignored.
- cs_n falling while in DONE (glitch without observed rise) is ignored; a new frame starts only from IDLE.
- Timing budget: 10 MHz SCLK gives 5 clocks per half period. First MISO bit is driven on the 16th falling edge, ≤ 4 clocks after that edge, so it is valid before the 17th rising edge.
- Reset asserted mid-frame: immediate return to reset values; the frame is lost and not counted.

Test Plan:
- Write frame 0x8004_00000123 (RW=1, addr 0x0004) at 10 MHz -> one data_mosi_rdy pulse; addr=16'h0004, data_mosi=32'h00000123; frame_err_cnt=0.
- Read frame header 0x0005 with rd_data=32'hA5C3_0F81 -> single rd_req with addr=16'h0005; MISO bits 16..47 reproduce 0xA5C30F81; no data_mosi_rdy.
- cs_n released after 20 bits of a write -> no data_mosi_rdy; data_mosi keeps previous value; frame_err_cnt=1.
- 300 consecutive aborted frames -> frame_err_cnt saturates at 8'hFF.
- Write frame with 52 SCLKs before cs_n rise -> exactly one data_mosi_rdy, data from bits 31:0; extra bits ignored; no error count.
- rst_syn pulsed during bit 30 of a read -> all outputs return to reset values; next frame decodes correctly.
